// File: rtl/wb_trace_buffer.sv
// rtl/wb_trace_buffer.sv - circular capture buffer for register-file writeback events
module wb_trace_buffer #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int REG_W     = 5,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8,
    parameter int SEQ_W     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wb_valid,
    input  logic [REG_W-1:0]         wb_rd,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic [ADDR_W-1:0]        wb_pc,
    input  logic                     arm,
    input  logic                     mode_wrap,
    input  logic                     skip_x0,
    input  logic                     trig_en,
    input  logic [ADDR_W-1:0]        trig_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDR_W-1:0]        out_pc,
    output logic [REG_W-1:0]         out_rd,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEQ_W-1:0]         out_seq,
    output logic [1:0]               state,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              dropped,
    output logic                     done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ARMED  = 2'b01,
        ST_POST   = 2'b10,
        ST_FROZEN = 2'b11
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PTR_W-1:0]    r_post_ctr;
    logic [PTR_W-1:0]    w_post_ctr_nxt;

    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [15:0]         r_dropped;
    logic [SEQ_W-1:0]    r_seq_ctr;

    logic [ADDR_W-1:0]   r_mem_pc   [DEPTH];
    logic [REG_W-1:0]    r_mem_rd   [DEPTH];
    logic [DATA_W-1:0]   r_mem_data [DEPTH];
    logic [SEQ_W-1:0]    r_mem_seq  [DEPTH];

    logic w_capturing;
    logic w_qual;
    logic w_trig_hit;
    logic w_full;
    logic w_pop;
    logic w_store;
    logic w_overwrite;
    logic w_write;
    logic w_drop;

    // An arm cycle flushes the buffer, so any event in that same cycle is not captured
    assign w_capturing = (r_state == ST_ARMED) || (r_state == ST_POST);
    assign w_qual      = wb_valid && w_capturing && !arm && !(skip_x0 && (wb_rd == '0));
    assign w_trig_hit  = trig_en && (wb_pc == trig_pc);
    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_pop       = out_valid && out_ready;
    // A push into a full buffer is only clean when the head leaves in the same cycle
    assign w_store     = w_qual && (!w_full || w_pop);
    assign w_overwrite = w_qual && w_full && !w_pop && mode_wrap;
    assign w_write     = w_store || w_overwrite;
    assign w_drop      = w_qual && w_full && !w_pop;

    // State and post-trigger counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_post_ctr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_post_ctr <= w_post_ctr_nxt;
        end
    end

    // Next-state logic: arm wins, trigger opens the post window, last window event freezes
    always_comb begin
        w_state_nxt    = r_state;
        w_post_ctr_nxt = r_post_ctr;
        if (arm) begin
            w_state_nxt    = ST_ARMED;
            w_post_ctr_nxt = '0;
        end else begin
            case (r_state)
                ST_ARMED: begin
                    if (w_qual && w_trig_hit) begin
                        if (POST_TRIG == 0) begin
                            w_state_nxt = ST_FROZEN;
                        end else begin
                            w_state_nxt    = ST_POST;
                            w_post_ctr_nxt = PTR_W'(POST_TRIG);
                        end
                    end
                end
                ST_POST: begin
                    if (w_qual) begin
                        w_post_ctr_nxt = r_post_ctr - 1'b1;
                        if (r_post_ctr == PTR_W'(1)) begin
                            w_state_nxt = ST_FROZEN;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Pointers, occupancy, sequence counter and saturating loss counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_dropped <= '0;
            r_seq_ctr <= '0;
        end else if (arm) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_dropped <= '0;
            r_seq_ctr <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            // Overwriting the oldest entry pushes the head forward as if it had been popped
            if (w_pop || w_overwrite) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_store && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_store && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (w_drop && (r_dropped != 16'hFFFF)) begin
                r_dropped <= r_dropped + 1'b1;
            end
            if (w_qual) begin
                r_seq_ctr <= r_seq_ctr + 1'b1;
            end
        end
    end

    // Entry storage; contents need no reset because reads are masked while empty
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem_pc[r_wr_ptr]   <= wb_pc;
            r_mem_rd[r_wr_ptr]   <= wb_rd;
            r_mem_data[r_wr_ptr] <= wb_data;
            r_mem_seq[r_wr_ptr]  <= r_seq_ctr;
        end
    end

    assign out_valid = (r_count != '0);
    assign out_pc    = out_valid ? r_mem_pc[r_rd_ptr]   : '0;
    assign out_rd    = out_valid ? r_mem_rd[r_rd_ptr]   : '0;
    assign out_data  = out_valid ? r_mem_data[r_rd_ptr] : '0;
    assign out_seq   = out_valid ? r_mem_seq[r_rd_ptr]  : '0;
    assign state     = r_state;
    assign count     = r_count;
    assign dropped   = r_dropped;
    assign done      = (r_state == ST_FROZEN);

endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb/tb_wb_trace_buffer.sv - directed self-checking bench for wb_trace_buffer
module tb_wb_trace_buffer;

    logic        clk;
    logic        reset;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] wb_pc;
    logic        arm;
    logic        mode_wrap;
    logic        skip_x0;
    logic        trig_en;
    logic [31:0] trig_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic [15:0] out_seq;
    logic [1:0]  state;
    logic [4:0]  count;
    logic [15:0] dropped;
    logic        done;

    int n_vectors;
    int n_miscompares;

    wb_trace_buffer #(
        .DATA_W(32), .ADDR_W(32), .REG_W(5), .DEPTH(16), .POST_TRIG(2), .SEQ_W(16)
    ) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_pc(wb_pc),
        .arm(arm), .mode_wrap(mode_wrap), .skip_x0(skip_x0),
        .trig_en(trig_en), .trig_pc(trig_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rd(out_rd), .out_data(out_data), .out_seq(out_seq),
        .state(state), .count(count), .dropped(dropped), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic wb_event(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] data);
        wb_valid = 1'b1;
        wb_pc    = pc;
        wb_rd    = rd;
        wb_data  = data;
        step();
        wb_valid = 1'b0;
    endtask

    initial begin
        n_vectors     = 0;
        n_miscompares = 0;
        reset     = 1'b0;
        wb_valid  = 1'b0;
        wb_rd     = '0;
        wb_data   = '0;
        wb_pc     = '0;
        arm       = 1'b0;
        mode_wrap = 1'b0;
        skip_x0   = 1'b0;
        trig_en   = 1'b0;
        trig_pc   = '0;
        out_ready = 1'b0;
        step();
        step();

        check_eq("rst_state", state, 2'b00);
        check_eq("rst_count", count, 0);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_pc", out_pc, 0);
        check_eq("rst_dropped", dropped, 0);
        check_eq("rst_done", done, 0);
        reset = 1'b1;
        step();

        // Events in IDLE are ignored
        wb_event(32'h40, 5'd9, 32'h99);
        check_eq("idle_ignore", count, 0);

        // Basic capture then drain
        do_arm();
        check_eq("armed_state", state, 2'b01);
        wb_event(32'h00, 5'd1, 32'd5);
        check_eq("lat_valid", out_valid, 1);
        wb_event(32'h04, 5'd2, 32'd6);
        wb_event(32'h08, 5'd3, 32'd7);
        check_eq("basic_count", count, 3);
        check_eq("basic_pc", out_pc, 32'h00);
        check_eq("basic_rd", out_rd, 1);
        check_eq("basic_data", out_data, 5);
        check_eq("basic_seq", out_seq, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_eq("drain_seq", out_seq, i);
            check_eq("drain_pc", out_pc, 4 * i);
            check_eq("drain_data", out_data, 5 + i);
            step();
        end
        out_ready = 1'b0;
        check_eq("drain_empty", out_valid, 0);
        check_eq("drain_count", count, 0);

        // Stop-when-full
        do_arm();
        mode_wrap = 1'b0;
        for (int i = 0; i < 20; i++) wb_event(4 * i, 5'd1, i);
        check_eq("stop_count", count, 16);
        check_eq("stop_dropped", dropped, 4);
        check_eq("stop_head", out_seq, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_eq("stop_seq", out_seq, i);
            step();
        end
        out_ready = 1'b0;
        check_eq("stop_empty", out_valid, 0);

        // Wrap mode
        do_arm();
        check_eq("arm_clr_drop", dropped, 0);
        mode_wrap = 1'b1;
        for (int i = 0; i < 20; i++) wb_event(4 * i, 5'd1, i);
        check_eq("wrap_count", count, 16);
        check_eq("wrap_dropped", dropped, 4);
        check_eq("wrap_head", out_seq, 4);
        check_eq("wrap_head_pc", out_pc, 32'h10);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_eq("wrap_seq", out_seq, 4 + i);
            step();
        end
        out_ready = 1'b0;
        check_eq("wrap_empty", out_valid, 0);
        mode_wrap = 1'b0;

        // Trigger with a two-event post window
        do_arm();
        trig_en = 1'b1;
        trig_pc = 32'h20;
        wb_event(32'h18, 5'd1, 1);
        check_eq("trig_s18", state, 2'b01);
        wb_event(32'h1C, 5'd1, 2);
        check_eq("trig_s1c", state, 2'b01);
        wb_event(32'h20, 5'd1, 3);
        check_eq("trig_s20", state, 2'b10);
        check_eq("trig_done0", done, 0);
        wb_event(32'h24, 5'd1, 4);
        check_eq("trig_s24", state, 2'b10);
        wb_event(32'h28, 5'd1, 5);
        check_eq("trig_s28", state, 2'b11);
        check_eq("trig_done", done, 1);
        wb_event(32'h2C, 5'd1, 6);
        check_eq("trig_count", count, 5);
        check_eq("trig_frozen", state, 2'b11);
        check_eq("trig_head", out_pc, 32'h18);

        // Reset mid-POST clears immediately and stays idle until arm
        do_arm();
        for (int i = 0; i < 5; i++) wb_event(32'h10 + 4 * i, 5'd1, i);
        check_eq("post_state", state, 2'b10);
        check_eq("post_count", count, 5);
        reset = 1'b0;
        #2;
        check_eq("async_state", state, 2'b00);
        check_eq("async_count", count, 0);
        check_eq("async_valid", out_valid, 0);
        step();
        reset = 1'b1;
        wb_event(32'h30, 5'd1, 1);
        wb_event(32'h20, 5'd1, 2);
        check_eq("post_rst_count", count, 0);
        check_eq("post_rst_state", state, 2'b00);
        trig_en = 1'b0;

        // skip_x0 filtering, then simultaneous push/pop at full
        do_arm();
        skip_x0 = 1'b1;
        wb_event(32'h00, 5'd0, 1);
        wb_event(32'h04, 5'd4, 2);
        wb_event(32'h08, 5'd0, 3);
        wb_event(32'h0C, 5'd7, 4);
        check_eq("skip_count", count, 2);
        check_eq("skip_seq0", out_seq, 0);
        check_eq("skip_rd0", out_rd, 4);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq("skip_seq1", out_seq, 1);
        check_eq("skip_rd1", out_rd, 7);
        for (int i = 0; i < 15; i++) wb_event(32'h100 + 4 * i, 5'd3, i);
        check_eq("full_count", count, 16);
        check_eq("full_dropped", dropped, 0);
        out_ready = 1'b1;
        wb_event(32'h200, 5'd5, 32'hAB);
        out_ready = 1'b0;
        check_eq("pp_count", count, 16);
        check_eq("pp_dropped", dropped, 0);
        check_eq("pp_head", out_seq, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/wb_trace_buffer.md
# wb_trace_buffer

Parametrised hardware capture buffer for register-file writeback events of the pipelined RISC-V core. Sits beside the MEM/WB pipeline register and records (pc, rd, data) for every qualifying writeback into a circular buffer. A sequence number, optional PC trigger with post-trigger window, and wrap or stop-when-full mode let the bench or a debug port drain the trace through a valid/ready interface, replacing ad-hoc `$monitor` dumps.

## Interface
- DATA_W, 32, writeback data width
- ADDR_W, 32, PC width
- REG_W, 5, register index width
- DEPTH, 16, entries; power of two, >= 2
- POST_TRIG, 8, events captured after the trigger event; 0..DEPTH-1
- SEQ_W, 16, sequence number width

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- wb_valid  in  1  writeback strobe (wb_rf_enable)
- wb_rd  in  REG_W  destination register
- wb_data  in  DATA_W  value written
- wb_pc  in  ADDR_W  PC of the retiring instruction
- arm  in  1  single-cycle pulse: flush and start capture
- mode_wrap  in  1  1 = overwrite oldest when full; 0 = drop new when full
- skip_x0  in  1  1 = ignore events with wb_rd == 0
- trig_en  in  1  enable PC trigger
- trig_pc  in  ADDR_W  trigger PC
- out_valid  out  1  head entry available
- out_ready  in  1  consumer accepts head
- out_pc / out_rd / out_data  out  ADDR_W / REG_W / DATA_W  head entry fields
- out_seq  out  SEQ_W  head entry sequence number
- state  out  2  00 IDLE, 01 ARMED, 10 POST, 11 FROZEN
- count  out  log2(DEPTH)+1  entries held
- dropped  out  16  lost events, saturates at 0xFFFF
- done  out  1  high in FROZEN

## Operation
- Qualifying event: wb_valid && state in {ARMED, POST} && !(skip_x0 && wb_rd == 0). Events in IDLE or FROZEN are ignored and not counted.
- Each qualifying event is stamped with seq_ctr, then seq_ctr increments (mod 2^SEQ_W), whether the event is stored or dropped. Gaps in out_seq expose loss.
- Storage: wr_ptr, rd_ptr of log2(DEPTH) bits, wrap naturally; count tracks occupancy 0..DEPTH.
- Pop: out_valid && out_ready → rd_ptr++, count--. Pop is allowed in every state.
- Push when count < DEPTH, or when count == DEPTH with a simultaneous pop: store at wr_ptr, wr_ptr++. Count net change = push − pop.
- Full, no pop, mode_wrap = 1: overwrite the oldest entry. wr_ptr++ and rd_ptr++, count stays DEPTH, dropped++.
- Full, no pop, mode_wrap = 0: event discarded, dropped++.
- arm: rd_ptr = wr_ptr = count = 0, seq_ctr = 0, dropped = 0, post_ctr = 0, state → ARMED. A wb event in the arm cycle is not captured. arm overrides every other transition.
- ARMED → POST: qualifying event with trig_en && wb_pc == trig_pc. That event is captured and post_ctr is loaded with POST_TRIG. With POST_TRIG == 0, the transition goes directly to FROZEN.
- POST: each later qualifying event decrements post_ctr. The event that takes it to 0 is captured and state → FROZEN.
- FROZEN: no capture. The buffer can be drained. Leaving FROZEN requires arm.
- With trig_en = 0, the block stays in ARMED indefinitely (free-running trace).
- mode_wrap, skip_x0, trig_en, trig_pc are sampled every cycle. Changes affect only the current and later events.

## Timing
- Reset (reset low, async): state IDLE, count 0, out_valid 0, out_* 0, dropped 0, done 0, seq_ctr 0, pointers 0. Memory contents are don't-care; out_* are forced to 0 while count == 0.
- Capture latency: an event sampled at edge N is visible as head (if the buffer was empty) with out_valid = 1 after edge N.
- out_* are combinational from the head storage entry and the pointers. They hold stable while out_valid && !out_ready.
- state, done, count, dropped are registered and update on the same edge as the causing event.
- Reset asserted mid-capture: immediate clear. Capture does not resume until arm.

## Test plan
- Reset then arm, then 3 events (pc 0x00,0x04,0x08; rd 1,2,3; data 5,6,7) with out_ready = 0 → count = 3, head pc 0x00 seq 0. Then out_ready = 1 for 3 cycles → seq 0,1,2 in order, then out_valid = 0.
- DEPTH = 16, mode_wrap = 0, 20 events, no drain → count = 16, dropped = 4, head seq 0. Drain all → last out_seq = 15.
- mode_wrap = 1, 20 events, no drain → count = 16, dropped = 4, head seq 4, last seq 19.
- trig_en = 1, trig_pc = 0x20, POST_TRIG = 2, events at pc 0x18,0x1C,0x20,0x24,0x28,0x2C → state 10 after 0x20, 11 after 0x28, done = 1. Entry 0x2C absent; count = 5.
- skip_x0 = 1, events rd = 0,4,0,7 → count = 2, out_seq 0 then 1. Then push and pop in the same cycle at full (DEPTH entries) → count unchanged, dropped unchanged.
- Assert reset for 1 cycle mid-POST with count = 5 → state 00, count 0, out_valid 0. Events after reset are ignored until arm.
